// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: decodes PS/2 make/break/extended scan codes,
// maps seven keys to notes and assigns held notes to voice slots with LRU stealing.
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      key_valid,
    input  logic [7:0]                keycode,
    input  logic                      all_off,
    output logic [3*NUM_VOICES-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trig,
    output logic                      steal,
    output logic [3:0]                active_count
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        ST_MAKE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    function automatic logic [2:0] map_key(input logic [7:0] code);
        logic [2:0] n;
        case (code)
            8'h16:   n = 3'd1;
            8'h1E:   n = 3'd2;
            8'h26:   n = 3'd3;
            8'h25:   n = 3'd4;
            8'h2E:   n = 3'd5;
            8'h36:   n = 3'd6;
            8'h3D:   n = 3'd7;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    state_t                 state_r, state_nx_s;
    logic [2:0]             note_r  [NUM_VOICES];
    logic [2:0]             note_nx_s [NUM_VOICES];
    logic [AGE_W-1:0]       age_r   [NUM_VOICES];
    logic [AGE_W-1:0]       age_nx_s [NUM_VOICES];
    logic [NUM_VOICES-1:0]  gate_nx_s;
    logic [NUM_VOICES-1:0]  trig_nx_s;
    logic                   steal_nx_s;
    logic [3:0]             count_nx_s;

    logic [2:0]             mapped_s;
    logic                   make_ev_s, brk_ev_s;
    logic                   held_any_s, any_free_s;
    logic [IDX_W-1:0]       held_idx_s, free_idx_s, oldest_idx_s, tgt_idx_s;

    assign mapped_s = map_key(keycode);

    // Scan-code prefix FSM: next state and make/break event decode
    always_comb begin
        state_nx_s = state_r;
        make_ev_s  = 1'b0;
        brk_ev_s   = 1'b0;
        if (all_off) begin
            state_nx_s = ST_MAKE;
        end else if (key_valid) begin
            case (state_r)
                ST_MAKE: begin
                    if (keycode == 8'hF0) begin
                        state_nx_s = ST_BRK;
                    end else if (keycode == 8'hE0) begin
                        state_nx_s = ST_EXT;
                    end else begin
                        state_nx_s = ST_MAKE;
                        make_ev_s  = (mapped_s != 3'd0);
                    end
                end
                ST_BRK: begin
                    if (keycode == 8'hF0) begin
                        state_nx_s = ST_BRK;
                    end else begin
                        state_nx_s = ST_MAKE;
                        brk_ev_s   = (mapped_s != 3'd0);
                    end
                end
                ST_EXT: begin
                    if (keycode == 8'hF0) begin
                        state_nx_s = ST_EXT_BRK;
                    end else begin
                        state_nx_s = ST_MAKE;
                    end
                end
                ST_EXT_BRK: state_nx_s = ST_MAKE;
                default:    state_nx_s = ST_MAKE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Slot search: voice holding the key, lowest free voice, and LRU voice
    always_comb begin
        held_any_s   = 1'b0;
        held_idx_s   = {IDX_W{1'b0}};
        any_free_s   = 1'b0;
        free_idx_s   = {IDX_W{1'b0}};
        oldest_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_gate[i] && (note_r[i] == mapped_s)) begin
                held_any_s = 1'b1;
                held_idx_s = IDX_W'(i);
            end else begin
                held_any_s = held_any_s;
            end
            if (!voice_gate[i]) begin
                any_free_s = 1'b1;
                free_idx_s = IDX_W'(i);
            end else begin
                any_free_s = any_free_s;
            end
            if (age_r[i] == AGE_W'(NUM_VOICES - 1)) begin
                oldest_idx_s = IDX_W'(i);
            end else begin
                oldest_idx_s = oldest_idx_s;
            end
        end
        tgt_idx_s = any_free_s ? free_idx_s : oldest_idx_s;
    end

    // Voice table update for make, break and panic
    always_comb begin
        note_nx_s  = note_r;
        age_nx_s   = age_r;
        gate_nx_s  = voice_gate;
        trig_nx_s  = {NUM_VOICES{1'b0}};
        steal_nx_s = 1'b0;
        if (all_off) begin
            gate_nx_s = {NUM_VOICES{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_nx_s[i] = 3'd0;
            end
        end else if (make_ev_s && !held_any_s) begin
            note_nx_s[tgt_idx_s] = mapped_s;
            gate_nx_s[tgt_idx_s] = 1'b1;
            trig_nx_s[tgt_idx_s] = 1'b1;
            steal_nx_s           = ~any_free_s;
            // Ages stay a permutation: voices younger than the target age by one
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (age_r[i] < age_r[tgt_idx_s]) begin
                    age_nx_s[i] = age_r[i] + AGE_W'(1);
                end else begin
                    age_nx_s[i] = age_r[i];
                end
            end
            age_nx_s[tgt_idx_s] = {AGE_W{1'b0}};
        end else if (brk_ev_s && held_any_s) begin
            note_nx_s[held_idx_s] = 3'd0;
            gate_nx_s[held_idx_s] = 1'b0;
        end else begin
            steal_nx_s = 1'b0;
        end
    end

    // Popcount of the next gate vector
    always_comb begin
        count_nx_s = 4'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_nx_s = count_nx_s + {3'd0, gate_nx_s[i]};
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_MAKE;
            voice_gate   <= {NUM_VOICES{1'b0}};
            voice_trig   <= {NUM_VOICES{1'b0}};
            steal        <= 1'b0;
            active_count <= 4'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= 3'd0;
                age_r[i]  <= AGE_W'(NUM_VOICES - 1 - i);
            end
        end else begin
            state_r      <= state_nx_s;
            voice_gate   <= gate_nx_s;
            voice_trig   <= trig_nx_s;
            steal        <= steal_nx_s;
            active_count <= count_nx_s;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= note_nx_s[i];
                age_r[i]  <= age_nx_s[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_out
        assign voice_note[3*g +: 3] = note_r[g];
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed vector table followed by
// randomized scan-code traffic checked against a queue-based LRU reference model.
module tb_voice_alloc;

    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            key_valid = 1'b0;
    logic [7:0]      keycode = 8'h00;
    logic            all_off = 1'b0;
    logic [3*NV-1:0] voice_note;
    logic [NV-1:0]   voice_gate;
    logic [NV-1:0]   voice_trig;
    logic            steal;
    logic [3:0]      active_count;

    int total = 0;
    int bad = 0;

    voice_alloc #(.NUM_VOICES(NV), .AGE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .keycode(keycode),
        .all_off(all_off), .voice_note(voice_note), .voice_gate(voice_gate),
        .voice_trig(voice_trig), .steal(steal), .active_count(active_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            kv;
        logic [7:0]      code;
        logic            aoff;
        logic [3*NV-1:0] note;
        logic [NV-1:0]   gate;
        logic [NV-1:0]   trig;
        logic            stl;
        logic [3:0]      cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic kv, input logic [7:0] c, input logic ao,
                                input int n3, input int n2, input int n1, input int n0,
                                input logic [3:0] g, input logic [3:0] t, input logic s,
                                input int cnt);
        vec_t v;
        v.rst = r; v.kv = kv; v.code = c; v.aoff = ao;
        v.note = {3'(n3), 3'(n2), 3'(n1), 3'(n0)};
        v.gate = g; v.trig = t; v.stl = s; v.cnt = 4'(cnt);
        return v;
    endfunction

    // ---------------- reference model ----------------
    int  m_note[NV];
    int  m_lru[$];          // voice indices, most recently assigned first
    bit  m_brk, m_ext;
    logic [NV-1:0] m_trig;
    bit  m_steal;

    function automatic int key_note(input logic [7:0] c);
        case (c)
            8'h16: return 1;
            8'h1E: return 2;
            8'h26: return 3;
            8'h25: return 4;
            8'h2E: return 5;
            8'h36: return 6;
            8'h3D: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic m_make(input int n);
        int v;
        v = -1;
        for (int i = 0; i < NV; i++) if (m_note[i] == n) return;
        for (int i = NV - 1; i >= 0; i--) if (m_note[i] == 0) v = i;
        if (v < 0) begin
            v = m_lru[$];
            m_steal = 1'b1;
        end
        m_note[v] = n;
        m_trig[v] = 1'b1;
        for (int k = 0; k < m_lru.size(); k++) begin
            if (m_lru[k] == v) begin
                m_lru.delete(k);
                break;
            end
        end
        m_lru.push_front(v);
    endtask

    task automatic m_step(input logic r, input logic kv, input logic [7:0] c, input logic ao);
        int n;
        m_trig = '0;
        m_steal = 1'b0;
        n = key_note(c);
        if (!r) begin
            for (int i = 0; i < NV; i++) m_note[i] = 0;
            m_lru.delete();
            for (int i = NV - 1; i >= 0; i--) m_lru.push_back(i);
            m_brk = 0; m_ext = 0;
        end else if (ao) begin
            for (int i = 0; i < NV; i++) m_note[i] = 0;
            m_brk = 0; m_ext = 0;
        end else if (kv) begin
            if (m_ext) begin
                if (!m_brk && c == 8'hF0) m_brk = 1;
                else begin m_brk = 0; m_ext = 0; end
            end else if (m_brk) begin
                if (c != 8'hF0) begin
                    m_brk = 0;
                    for (int i = 0; i < NV; i++) if (n != 0 && m_note[i] == n) m_note[i] = 0;
                end
            end else if (c == 8'hF0) m_brk = 1;
            else if (c == 8'hE0) m_ext = 1;
            else if (n != 0) m_make(n);
        end
    endtask

    // ---------------- drive / check ----------------
    task automatic apply(input logic r, input logic kv, input logic [7:0] c, input logic ao);
        rst_n = r; key_valid = kv; keycode = c; all_off = ao;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [3*NV-1:0] en,
                         input logic [NV-1:0] eg, input logic [NV-1:0] et, input logic es,
                         input logic [3:0] ec);
        total++;
        if (voice_note !== en || voice_gate !== eg || voice_trig !== et ||
            steal !== es || active_count !== ec) begin
            bad++;
            $display("FAIL %s[%0d]: got note=%h gate=%b trig=%b steal=%b cnt=%0d, want note=%h gate=%b trig=%b steal=%b cnt=%0d",
                     name, idx, voice_note, voice_gate, voice_trig, steal, active_count,
                     en, eg, et, es, ec);
        end
    endtask

    logic [7:0] pool[12];

    initial begin
        // 1: basic make
        vecs.push_back(mk(0,0,8'h00,0, 0,0,0,0, 4'b0000,4'b0000,0,0));
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,1, 4'b0001,4'b0001,0,1));
        vecs.push_back(mk(1,0,8'h00,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        // 2: fill all voices, then steal LRU twice
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'h1E,0, 0,0,2,1, 4'b0011,4'b0010,0,2));
        vecs.push_back(mk(1,1,8'h26,0, 0,3,2,1, 4'b0111,4'b0100,0,3));
        vecs.push_back(mk(1,1,8'h25,0, 4,3,2,1, 4'b1111,4'b1000,0,4));
        vecs.push_back(mk(1,1,8'h2E,0, 4,3,2,5, 4'b1111,4'b0001,1,4));
        vecs.push_back(mk(1,0,8'h00,0, 4,3,2,5, 4'b1111,4'b0000,0,4));
        vecs.push_back(mk(1,1,8'h36,0, 4,3,6,5, 4'b1111,4'b0010,1,4));
        // 3: break held note, then break of unheld note
        vecs.push_back(mk(0,0,8'h00,0, 0,0,0,0, 4'b0000,4'b0000,0,0));
        vecs.push_back(mk(1,1,8'h1E,0, 0,0,0,2, 4'b0001,4'b0001,0,1));
        vecs.push_back(mk(1,1,8'hF0,0, 0,0,0,2, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'h1E,0, 0,0,0,0, 4'b0000,4'b0000,0,0));
        vecs.push_back(mk(1,1,8'hF0,0, 0,0,0,0, 4'b0000,4'b0000,0,0));
        vecs.push_back(mk(1,1,8'h26,0, 0,0,0,0, 4'b0000,4'b0000,0,0));
        // 4: typematic repeat
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,1, 4'b0001,4'b0001,0,1));
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        // 5: extended break ignored, double F0 break honoured
        vecs.push_back(mk(1,1,8'hE0,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'hF0,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'hF0,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'hF0,0, 0,0,0,1, 4'b0001,4'b0000,0,1));
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,0, 4'b0000,4'b0000,0,0));
        // 6: all_off beats key_valid
        vecs.push_back(mk(1,1,8'h16,0, 0,0,0,1, 4'b0001,4'b0001,0,1));
        vecs.push_back(mk(1,1,8'h1E,0, 0,0,2,1, 4'b0011,4'b0010,0,2));
        vecs.push_back(mk(1,1,8'h26,0, 0,3,2,1, 4'b0111,4'b0100,0,3));
        vecs.push_back(mk(1,1,8'h1E,1, 0,0,0,0, 4'b0000,4'b0000,0,0));
        vecs.push_back(mk(1,0,8'h00,0, 0,0,0,0, 4'b0000,4'b0000,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].kv, vecs[i].code, vecs[i].aoff);
            check("vec", i, vecs[i].note, vecs[i].gate, vecs[i].trig, vecs[i].stl, vecs[i].cnt);
        end

        // Reset after F0 discards the prefix: 16 becomes a make
        apply(1'b1, 1'b1, 8'hF0, 1'b0);
        apply(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_mid_seq_clear", 0, '0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        apply(1'b1, 1'b1, 8'h16, 1'b0);
        check("rst_mid_seq_make", 0, {3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 4'b0001, 1'b0, 4'd1);

        // all_off after F0 also discards the prefix
        apply(1'b1, 1'b1, 8'hF0, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b1);
        check("alloff_prefix_clear", 0, '0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        apply(1'b1, 1'b1, 8'h1E, 1'b0);
        check("alloff_prefix_make", 0, {3'd0, 3'd0, 3'd0, 3'd2}, 4'b0001, 4'b0001, 1'b0, 4'd1);

        // Randomized traffic against the reference model
        pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'hF0, 8'hF0, 8'hE0, 8'h00, 8'h5A};
        m_step(1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b0, 1'b0, 8'h00, 1'b0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic r, kv, ao;
            logic [7:0] c;
            logic [3*NV-1:0] en;
            logic [NV-1:0] eg;
            int ec;
            r  = ($urandom_range(0, 199) != 0);
            kv = ($urandom_range(0, 9) < 7);
            ao = ($urandom_range(0, 99) < 2);
            c  = pool[$urandom_range(0, 11)];
            if (c == 8'h5A) c = 8'($urandom_range(0, 255));
            m_step(r, kv, c, ao);
            ec = 0;
            for (int i = 0; i < NV; i++) begin
                en[3*i +: 3] = 3'(m_note[i]);
                eg[i] = (m_note[i] != 0);
                ec += int'(eg[i]);
            end
            apply(r, kv, c, ao);
            check("rand", cyc, en, eg, m_trig, m_steal, 4'(ec));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
